// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port bundle for mem_port_arbiter
//
// Purpose: groups the fetch (I) requester, data (D) requester and memory-port
// signals of the unified-memory arbiter into one bundle.
// Modports:
//   slave  - arbiter side: takes requests and memRdata, drives responses,
//            stall lines and the memory command.
//   master - environment side (requesters plus memory), the mirror image.
// Signals:
//   iReq/iAddr            fetch request, held until iValid
//   iRdata/iValid/iStall  fetch response, completion pulse, stall
//   dReq/dWe/dAddr/dWdata data request, held until dValid
//   dRdata/dValid/dStall  data response, completion pulse, stall
//   memEn/memWe/memAddr/memWdata  memory command
//   memRdata              memory read data, valid in the last access cycle
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iReq;
    logic [ADDR_W-1:0] iAddr;
    logic [DATA_W-1:0] iRdata;
    logic              iValid;
    logic              iStall;

    logic              dReq;
    logic              dWe;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWdata;
    logic [DATA_W-1:0] dRdata;
    logic              dValid;
    logic              dStall;

    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;

    modport slave (
        input  iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
        output iRdata, iValid, iStall, dRdata, dValid, dStall,
               memEn, memWe, memAddr, memWdata
    );

    modport master (
        output iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
        input  iRdata, iValid, iStall, dRdata, dValid, dStall,
               memEn, memWe, memAddr, memWdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority I/D arbiter for a single-ported fixed-latency memory
//
// Purpose: shares one memory between instruction fetch (I) and the data
// stage (D). One access at a time: IDLE -> ACCESS (LATENCY cycles) -> DONE
// (one-cycle valid pulse) -> IDLE. D wins ties unless I has been passed over
// STARVE_LIMIT times in a row, in which case I is forced.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (requesters, responses, memory port)
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [1:0]          state;
    logic                ownerD;   // 1 = current access belongs to D
    logic                weReg;
    logic [ADDR_W-1:0]   addrReg;
    logic [DATA_W-1:0]   wdataReg;
    logic [DATA_W-1:0]   rdataReg;
    logic [CNT_W-1:0]    cnt;
    logic [STARVE_W-1:0] starve;   // consecutive D grants while I waited

    logic anyReq;
    logic grantD;

    always_comb begin
        anyReq = bus.iReq | bus.dReq;
        // D wins unless I has waited through STARVE_LIMIT D grants.
        grantD = bus.dReq & (~bus.iReq | (starve != STARVE_MAX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ownerD   <= 1'b0;
            weReg    <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            rdataReg <= '0;
            cnt      <= '0;
            starve   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        ownerD   <= grantD;
                        weReg    <= grantD & bus.dWe;
                        addrReg  <= grantD ? bus.dAddr : bus.iAddr;
                        wdataReg <= grantD ? bus.dWdata : '0;
                        cnt      <= CNT_LOAD;
                        state    <= ACCESS;
                        if (grantD && bus.iReq) begin
                            if (starve != STARVE_MAX) begin
                                starve <= starve + STARVE_W'(1);
                            end
                        end else begin
                            starve <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Writes keep the last read result visible.
                        if (!weReg) begin
                            rdataReg <= bus.memRdata;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs decode from state, so reset drops them at once and
    // memRdata never reaches an output combinationally.
    assign bus.memEn    = (state == ACCESS);
    assign bus.memWe    = (state == ACCESS) & weReg;
    assign bus.memAddr  = addrReg;
    assign bus.memWdata = wdataReg;

    assign bus.iValid = (state == DONE) & ~ownerD;
    assign bus.dValid = (state == DONE) & ownerD;
    assign bus.iRdata = rdataReg;
    assign bus.dRdata = rdataReg;

    // Stall releases in the DONE cycle so the requester advances on that edge.
    assign bus.iStall = bus.iReq & ~bus.iValid;
    assign bus.dStall = bus.dReq & ~bus.dValid;
endmodule
